pos_embedding: RTL and testbench

- Learned-position-embedding lookup stage of the transformer front end.
- Maps a token position index to an N_EMBD-element vector of 8-bit values, read from a fixed on-chip table.
- Output is registered: one clock of latency, fed to the token+position adder downstream.

---
 rtl/pos_embedding_pkg.sv | 14 +
 rtl/pos_embedding_rom.sv | 32 +++
 rtl/pos_embedding.sv | 36 +++
 tb/tb_pos_embedding.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pos_embedding_pkg.sv
// rtl/pos_embedding_pkg.sv - shared types and table initialiser for the position embedding lookup
package pos_embedding_pkg;

    localparam int EMB_W = 8;

    typedef logic [EMB_W-1:0] emb_t;

    // Flat index is formed in 32 bits, then only the low byte is kept (wraps, no saturation).
    function automatic emb_t pos_emb_init(input int unsigned p, input int unsigned j,
                                          input int unsigned n_embd);
        return emb_t'(p * n_embd + j);
    endfunction

endpackage

// File: rtl/pos_embedding_rom.sv
// rtl/pos_embedding_rom.sv - constant position embedding table with zero row for out-of-range positions
module pos_embedding_rom
    import pos_embedding_pkg::*;
#(
    parameter int N_POS  = 8,
    parameter int N_EMBD = 4
) (
    input  logic [$clog2(N_POS)-1:0] pos,
    output emb_t                     row [0:N_EMBD-1]
);

    emb_t        table_data [0:N_POS-1][0:N_EMBD-1];
    int unsigned pos_idx;

    for (genvar p = 0; p < N_POS; p++) begin : g_row
        for (genvar j = 0; j < N_EMBD; j++) begin : g_col
            assign table_data[p][j] = pos_emb_init(p, j, N_EMBD);
        end
    end

    // Non-power-of-two N_POS leaves encodable pos values past the last row; they read as zeros.
    always_comb begin
        pos_idx = 32'(pos);
        for (int j = 0; j < N_EMBD; j++) begin
            row[j] = '0;
            if (pos_idx < N_POS) begin
                row[j] = table_data[pos][j];
            end
        end
    end

endmodule

// File: rtl/pos_embedding.sv
// rtl/pos_embedding.sv - registered learned position embedding lookup, one cycle latency
module pos_embedding
    import pos_embedding_pkg::*;
#(
    parameter int N_POS  = 8,
    parameter int N_EMBD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(N_POS)-1:0] pos,
    output emb_t                     embedding [0:N_EMBD-1]
);

    emb_t row [0:N_EMBD-1];

    pos_embedding_rom #(
        .N_POS  (N_POS),
        .N_EMBD (N_EMBD)
    ) u_rom (
        .pos (pos),
        .row (row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_EMBD; j++) begin
                embedding[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N_EMBD; j++) begin
                embedding[j] <= row[j];
            end
        end
    end

endmodule

// File: tb/tb_pos_embedding.sv
// tb/tb_pos_embedding.sv - self-checking bench for pos_embedding across three table shapes
module tb_pos_embedding;

    logic       clk;
    logic       rst_n;
    logic [2:0] pos8;
    logic [6:0] pos128;
    logic [2:0] pos6;
    logic [7:0] e8   [0:3];
    logic [7:0] e128 [0:3];
    logic [7:0] e6   [0:3];

    int errors = 0;
    int checks = 0;

    pos_embedding #(.N_POS(8), .N_EMBD(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .pos(pos8), .embedding(e8)
    );
    pos_embedding #(.N_POS(128), .N_EMBD(4)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .pos(pos128), .embedding(e128)
    );
    pos_embedding #(.N_POS(6), .N_EMBD(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .pos(pos6), .embedding(e6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: flat index of row p, column j, kept to one byte; rows past the table are zero.
    function automatic logic [7:0] model(input int n_pos, input int p, input int j);
        if (p >= n_pos) return 8'd0;
        return 8'((p * 4 + j) % 256);
    endfunction

    task automatic check_one(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit in_reset,
                             input int p8, input int p128, input int p6);
        for (int j = 0; j < 4; j++) begin
            check_one($sformatf("%s n8 p=%0d j=%0d", tag, p8, j), e8[j],
                      in_reset ? 8'd0 : model(8, p8, j));
            check_one($sformatf("%s n128 p=%0d j=%0d", tag, p128, j), e128[j],
                      in_reset ? 8'd0 : model(128, p128, j));
            check_one($sformatf("%s n6 p=%0d j=%0d", tag, p6, j), e6[j],
                      in_reset ? 8'd0 : model(6, p6, j));
        end
    endtask

    // Called at a negedge: drive, let one rising edge register it, check at the next negedge.
    task automatic step(input string tag, input int p8, input int p128, input int p6);
        pos8   = 3'(p8);
        pos128 = 7'(p128);
        pos6   = 3'(p6);
        @(posedge clk);
        @(negedge clk);
        check_all(tag, 1'b0, p8, p128, p6);
    endtask

    initial begin
        rst_n  = 1'b1;
        pos8   = 3'd5;
        pos128 = 7'd5;
        pos6   = 3'd5;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check_all("reset_async", 1'b1, 5, 5, 5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset_held", 1'b1, 5, 5, 5);

        rst_n = 1'b1;
        for (int p = 0; p < 8; p++) begin
            step("sweep", p, p * 16 + 3, p);
        end

        // Latency: pos change right after an edge must not show until the following edge
        step("lat_a", 2, 10, 2);
        @(posedge clk);
        #1 pos8 = 3'd6;
        #2 check_all("lat_hold", 1'b0, 2, 10, 2);
        @(negedge clk);
        check_all("lat_hold2", 1'b0, 2, 10, 2);
        @(posedge clk);
        @(negedge clk);
        check_all("lat_new", 1'b0, 6, 10, 2);

        step("wrap", 0, 64, 7);
        step("wrap", 7, 63, 5);
        step("wrap", 1, 127, 6);

        for (int i = 0; i < 40; i++) begin
            step("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)));
        end

        // Reset pulsed between edges mid-stream
        step("mid_pre", 4, 100, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all("mid_reset", 1'b1, 4, 100, 3);
        pos8   = 3'd1;
        pos128 = 7'd65;
        pos6   = 3'd4;
        @(negedge clk);
        check_all("mid_reset_held", 1'b1, 1, 65, 4);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all("post_reset", 1'b0, 1, 65, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
